// File: rtl/acsp_pkg.sv
// acsp_pkg
// Shared definitions for the ACSP host command path: opcode constants, the bit
// that marks a long (argument-carrying) opcode, and the command decoder state
// encoding.
package acsp_pkg;

    localparam logic [7:0] OP_RESET    = 8'h00;
    localparam logic [7:0] OP_RUN      = 8'h01;
    localparam logic [7:0] OP_ID       = 8'h02;
    localparam logic [7:0] OP_METADATA = 8'h04;

    // Opcodes with this bit set are followed by a 32-bit little-endian argument.
    localparam int LONG_CMD_BIT = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARG  = 2'd1,
        HOLD = 2'd2
    } cmd_dec_state_t;

endpackage

// File: rtl/acsp_timeout_counter.sv
// acsp_timeout_counter
// Counts enabled cycles since the last clear and flags when the count reaches
// CYCLES-1. The count saturates there instead of wrapping.
//
// Ports:
//   system_clock  in   clock
//   reset_n       in   asynchronous active-low reset
//   clear         in   force the count to zero (wins over enable)
//   enable        in   advance the count by one this cycle
//   expired       out  count has reached CYCLES-1 (combinational from the count)
module acsp_timeout_counter #(
    parameter int CYCLES = 1_000_000
) (
    input  logic system_clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] count;

    assign expired = (count == W'(CYCLES - 1));

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/acsp_cmd_decoder.sv
// acsp_cmd_decoder
// Frames the UART receive byte stream into host commands. A short command is
// a single opcode byte with bit 7 clear; a long command is an opcode with bit 7
// set followed by four argument bytes, least significant first. Completed
// commands are held on a valid/ready interface. A stalled argument stream is
// discarded after TIMEOUT_CYCLES idle cycles so the host can resynchronise.
//
// Ports:
//   system_clock  in   clock
//   reset_n       in   asynchronous active-low reset
//   rx_data       in   received byte, qualified by rx_valid
//   rx_valid      in   one-cycle strobe per received byte (no backpressure)
//   cmd_valid     out  a complete command is presented
//   cmd_ready     in   consumer accepts the presented command
//   cmd_opcode    out  opcode of the presented command
//   cmd_arg       out  32-bit argument, first argument byte in [7:0]; 0 if short
//   cmd_long      out  presented command carries an argument
//   err_timeout   out  one-cycle pulse: partial long command discarded
//   err_overrun   out  one-cycle pulse: byte dropped while a command was pending
module acsp_cmd_decoder
    import acsp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        system_clock,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_opcode,
    output logic [31:0] cmd_arg,
    output logic        cmd_long,
    output logic        err_timeout,
    output logic        err_overrun
);

    cmd_dec_state_t state, state_next;

    logic [1:0]  arg_cnt, arg_cnt_next;
    logic [7:0]  opcode_next;
    logic [31:0] arg_next;
    logic        long_next;
    logic        err_timeout_next;
    logic        err_overrun_next;
    logic        take_opcode;

    logic to_clear, to_enable, to_expired;

    // The counter only runs while argument bytes are outstanding; every
    // received byte restarts the inter-byte window.
    assign to_clear  = (state != ARG) || rx_valid;
    assign to_enable = (state == ARG) && !rx_valid;

    acsp_timeout_counter #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .clear        (to_clear),
        .enable       (to_enable),
        .expired      (to_expired)
    );

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        arg_cnt_next     = arg_cnt;
        opcode_next      = cmd_opcode;
        arg_next         = cmd_arg;
        long_next        = cmd_long;
        err_timeout_next = 1'b0;
        err_overrun_next = 1'b0;
        take_opcode      = 1'b0;

        case (state)
            IDLE: begin
                take_opcode = rx_valid;
            end
            ARG: begin
                // A byte arriving in the expiry cycle takes priority over the timeout.
                if (rx_valid) begin
                    arg_next[{arg_cnt, 3'b000} +: 8] = rx_data;
                    arg_cnt_next = arg_cnt + 2'd1;
                    if (arg_cnt == 2'd3) begin
                        state_next = HOLD;
                        long_next  = 1'b1;
                    end
                end else if (to_expired) begin
                    state_next       = IDLE;
                    err_timeout_next = 1'b1;
                    arg_next         = '0;
                end
            end
            HOLD: begin
                if (cmd_ready) begin
                    // A byte in the transfer cycle starts the next command with no bubble.
                    take_opcode = rx_valid;
                    if (!rx_valid) begin
                        state_next = IDLE;
                    end
                end else if (rx_valid) begin
                    err_overrun_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (take_opcode) begin
            opcode_next  = rx_data;
            arg_next     = '0;
            long_next    = 1'b0;
            arg_cnt_next = 2'd0;
            state_next   = rx_data[LONG_CMD_BIT] ? ARG : HOLD;
        end
    end

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            arg_cnt     <= 2'd0;
            cmd_valid   <= 1'b0;
            cmd_opcode  <= 8'h00;
            cmd_arg     <= 32'h0;
            cmd_long    <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            arg_cnt     <= arg_cnt_next;
            cmd_valid   <= (state_next == HOLD);
            cmd_opcode  <= opcode_next;
            cmd_arg     <= arg_next;
            cmd_long    <= long_next;
            err_timeout <= err_timeout_next;
            err_overrun <= err_overrun_next;
        end
    end

endmodule

// File: tb/tb_acsp_cmd_decoder.sv
// tb_acsp_cmd_decoder
// Directed stimulus for acsp_cmd_decoder. A command-level model (pending
// command, queue of collected argument bytes, count of silent cycles) predicts
// the outputs; a compare process checks them every cycle, and the stimulus
// adds literal expectations at key points.
module tb_acsp_cmd_decoder;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_arg;
    logic        cmd_long;
    logic        err_timeout;
    logic        err_overrun;

    int checks = 0;
    int errors = 0;

    acsp_cmd_decoder #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .system_clock (clk),
        .reset_n      (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_arg      (cmd_arg),
        .cmd_long     (cmd_long),
        .err_timeout  (err_timeout),
        .err_overrun  (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_pend;
    bit          m_collect;
    logic [7:0]  m_op;
    logic [31:0] m_arg;
    bit          m_long;
    bit          m_to;
    bit          m_ov;
    int          m_silence;
    logic [7:0]  m_bytes[$];

    task automatic m_start(input logic [7:0] b);
        m_op = b;
        if (b[7]) begin
            m_collect = 1;
            m_silence = 0;
            m_bytes.delete();
        end else begin
            m_pend = 1;
            m_arg  = 32'h0;
            m_long = 0;
        end
    endtask

    task automatic m_step();
        if (!rst_n) begin
            m_pend = 0; m_collect = 0; m_op = 8'h00; m_arg = 32'h0;
            m_long = 0; m_to = 0; m_ov = 0; m_silence = 0;
            m_bytes.delete();
            return;
        end
        m_to = 0;
        m_ov = 0;
        if (m_pend) begin
            if (cmd_ready) begin
                m_pend = 0;
                if (rx_valid) m_start(rx_data);
            end else if (rx_valid) begin
                m_ov = 1;
            end
        end else if (m_collect) begin
            if (rx_valid) begin
                m_bytes.push_back(rx_data);
                m_silence = 0;
                if (m_bytes.size() == 4) begin
                    m_collect = 0;
                    m_pend    = 1;
                    m_long    = 1;
                    m_arg     = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                end
            end else begin
                m_silence++;
                if (m_silence == TO) begin
                    m_collect = 0;
                    m_to      = 1;
                    m_bytes.delete();
                end
            end
        end else if (rx_valid) begin
            m_start(rx_data);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            m_step();
        end
    end

    // ---------------- compare process ----------------
    int          xfer_cnt = 0;
    logic [7:0]  last_op;
    logic [31:0] last_arg;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("cmp_valid", 32'(cmd_valid), 32'(m_pend));
                chk("cmp_err_timeout", 32'(err_timeout), 32'(m_to));
                chk("cmp_err_overrun", 32'(err_overrun), 32'(m_ov));
                if (m_pend) begin
                    chk("cmp_opcode", 32'(cmd_opcode), 32'(m_op));
                    chk("cmp_arg", cmd_arg, m_arg);
                    chk("cmp_long", 32'(cmd_long), 32'(m_long));
                end
                if (cmd_valid && cmd_ready) begin
                    xfer_cnt++;
                    last_op  = cmd_opcode;
                    last_arg = cmd_arg;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    int xfer_base;

    initial begin
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        cmd_ready = 1'b0;
        idle(3);
        chk("rst_valid", 32'(cmd_valid), 32'h0);
        chk("rst_opcode", 32'(cmd_opcode), 32'h0);
        chk("rst_arg", cmd_arg, 32'h0);
        chk("rst_long", 32'(cmd_long), 32'h0);
        chk("rst_err_timeout", 32'(err_timeout), 32'h0);
        chk("rst_err_overrun", 32'(err_overrun), 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Short command 0x04 with the consumer always ready.
        cmd_ready = 1'b1;
        send_byte(8'h04);
        chk("short_valid", 32'(cmd_valid), 32'h1);
        chk("short_opcode", 32'(cmd_opcode), 32'h04);
        chk("short_arg", cmd_arg, 32'h0);
        idle(1);
        chk("short_valid_fall", 32'(cmd_valid), 32'h0);
        idle(2);

        // Five back-to-back 0x00 resync bytes give five commands.
        xfer_base = xfer_cnt;
        for (int i = 0; i < 5; i++) send_byte(8'h00);
        idle(3);
        chk("resync_xfers", 32'(xfer_cnt - xfer_base), 32'd5);

        // Long command 0x81 with argument 0x12345678.
        send_byte(8'h81);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        chk("long_not_early", 32'(cmd_valid), 32'h0);
        send_byte(8'h12);
        chk("long_valid", 32'(cmd_valid), 32'h1);
        chk("long_opcode", 32'(cmd_opcode), 32'h81);
        chk("long_arg", cmd_arg, 32'h12345678);
        chk("long_flag", 32'(cmd_long), 32'h1);
        idle(3);

        // Partial long command abandoned; timeout pulse, then recovery.
        send_byte(8'hC0);
        send_byte(8'h11);
        idle(TO);
        chk("timeout_pulse", 32'(err_timeout), 32'h1);
        chk("timeout_no_cmd", 32'(cmd_valid), 32'h0);
        idle(1);
        chk("timeout_pulse_len", 32'(err_timeout), 32'h0);
        send_byte(8'h01);
        chk("after_to_opcode", 32'(cmd_opcode), 32'h01);
        chk("after_to_valid", 32'(cmd_valid), 32'h1);
        idle(3);

        // Argument bytes arriving exactly in the expiry cycle are accepted.
        send_byte(8'hC5);
        idle(TO - 1); send_byte(8'hEF);
        idle(TO - 1); send_byte(8'hBE);
        idle(TO - 1); send_byte(8'hAD);
        idle(TO - 1); send_byte(8'hDE);
        chk("edge_valid", 32'(cmd_valid), 32'h1);
        chk("edge_arg", cmd_arg, 32'hDEADBEEF);
        idle(3);

        // Overrun while a command is pending, then a single transfer.
        cmd_ready = 1'b0;
        send_byte(8'h02);
        send_byte(8'h01);
        chk("overrun_pulse", 32'(err_overrun), 32'h1);
        chk("overrun_hold_op", 32'(cmd_opcode), 32'h02);
        idle(3);
        chk("overrun_still_valid", 32'(cmd_valid), 32'h1);
        xfer_base = xfer_cnt;
        cmd_ready = 1'b1;
        idle(4);
        chk("overrun_one_xfer", 32'(xfer_cnt - xfer_base), 32'd1);
        chk("overrun_xfer_op", 32'(last_op), 32'h02);

        // Zero-bubble: new opcode in the transfer cycle of a pending command.
        cmd_ready = 1'b0;
        send_byte(8'h02);
        idle(2);
        cmd_ready = 1'b1;
        send_byte(8'h01);
        chk("zb_valid", 32'(cmd_valid), 32'h1);
        chk("zb_opcode", 32'(cmd_opcode), 32'h01);
        chk("zb_no_overrun", 32'(err_overrun), 32'h0);
        idle(3);

        // Reset in the middle of a long command.
        send_byte(8'h81);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(cmd_valid), 32'h0);
        chk("midrst_opcode", 32'(cmd_opcode), 32'h0);
        chk("midrst_arg", cmd_arg, 32'h0);
        chk("midrst_long", 32'(cmd_long), 32'h0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send_byte(8'h00);
        chk("postrst_valid", 32'(cmd_valid), 32'h1);
        chk("postrst_opcode", 32'(cmd_opcode), 32'h00);
        chk("postrst_arg", cmd_arg, 32'h0);
        chk("postrst_long", 32'(cmd_long), 32'h0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
